// File: rtl/exu_bjp_cmtgen_if.sv
// Execute-to-commit branch bundle: execute handshake, commit head, flush redirect, statistics.
// master = surrounding pipeline, slave = commit generator.
interface exu_bjp_cmtgen_if #(
   parameter int PC_SIZE = 32,
   parameter int XLEN    = 32
);
   logic               bjp_i_valid;
   logic               bjp_i_ready;
   logic               bjp_i_bjp;
   logic               bjp_i_prdt;
   logic               bjp_i_taken;
   logic [PC_SIZE-1:0] bjp_i_pc;
   logic [XLEN-1:0]    bjp_i_imm;

   logic               cmt_o_valid;
   logic               cmt_o_ready;
   logic               cmt_o_bjp;
   logic               cmt_o_bjp_prdt;
   logic [PC_SIZE-1:0] cmt_o_pc;
   logic [XLEN-1:0]    cmt_o_imm;

   logic               flush_o_req;
   logic               flush_o_ack;
   logic [PC_SIZE-1:0] flush_o_pc;

   logic [31:0]        bjp_cnt;
   logic [31:0]        mis_cnt;

   modport master (
      output bjp_i_valid, bjp_i_bjp, bjp_i_prdt, bjp_i_taken, bjp_i_pc, bjp_i_imm,
      output cmt_o_ready, flush_o_ack,
      input  bjp_i_ready, cmt_o_valid, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_pc, cmt_o_imm,
      input  flush_o_req, flush_o_pc, bjp_cnt, mis_cnt
   );

   modport slave (
      input  bjp_i_valid, bjp_i_bjp, bjp_i_prdt, bjp_i_taken, bjp_i_pc, bjp_i_imm,
      input  cmt_o_ready, flush_o_ack,
      output bjp_i_ready, cmt_o_valid, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_pc, cmt_o_imm,
      output flush_o_req, flush_o_pc, bjp_cnt, mis_cnt
   );
endinterface

// File: rtl/exu_bjp_cmtgen.sv
// Branch commit generator: queues resolved branches in order, commits them, and raises a
// redirect (discarding younger wrong-path entries) when a mispredicted branch commits.
module exu_bjp_cmtgen #(
   parameter int DEPTH   = 2,
   parameter int PC_SIZE = 32,
   parameter int XLEN    = 32
) (
   input logic             clk,
   input logic             rst,
   exu_bjp_cmtgen_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {RUN, FLUSH} state_t;

   typedef struct packed {
      logic               bjp;
      logic               prdt;
      logic               mis;
      logic [PC_SIZE-1:0] pc;
      logic [XLEN-1:0]    imm;
      logic [PC_SIZE-1:0] tgt;
   } entry_t;

   state_t             state, state_nxt;
   entry_t             mem [DEPTH];
   entry_t             head;
   entry_t             entry_in;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   cnt;
   logic               empty, full, push, pop, flush_done;
   logic [PC_SIZE-1:0] flush_pc;
   logic [31:0]        bjp_cnt_q, mis_cnt_q;

   assign empty      = (cnt == '0);
   assign full       = (cnt == CNT_W'(DEPTH));
   assign head       = mem[rd_ptr];
   assign flush_done = (state == FLUSH) && bus.flush_o_ack;

   assign bus.bjp_i_ready = !full && (state == RUN);
   assign bus.cmt_o_valid = !empty && (state == RUN);
   assign push = bus.bjp_i_valid && bus.bjp_i_ready;
   assign pop  = bus.cmt_o_valid && bus.cmt_o_ready;

   assign bus.cmt_o_bjp      = head.bjp;
   assign bus.cmt_o_bjp_prdt = head.prdt;
   assign bus.cmt_o_pc       = head.pc;
   assign bus.cmt_o_imm      = head.imm;
   assign bus.flush_o_req    = (state == FLUSH);
   assign bus.flush_o_pc     = flush_pc;
   assign bus.bjp_cnt        = bjp_cnt_q;
   assign bus.mis_cnt        = mis_cnt_q;

   // Redirect target and mispredict flag are resolved once, at push time.
   always_comb begin
      entry_in.bjp  = bus.bjp_i_bjp;
      entry_in.prdt = bus.bjp_i_prdt;
      entry_in.mis  = bus.bjp_i_bjp && (bus.bjp_i_prdt != bus.bjp_i_taken);
      entry_in.pc   = bus.bjp_i_pc;
      entry_in.imm  = bus.bjp_i_imm;
      entry_in.tgt  = bus.bjp_i_taken ? bus.bjp_i_pc + bus.bjp_i_imm[PC_SIZE-1:0]
                                      : bus.bjp_i_pc + PC_SIZE'(4);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (pop && head.mis) state_nxt = FLUSH;
         FLUSH:   if (bus.flush_o_ack) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         flush_pc  <= '0;
         bjp_cnt_q <= '0;
         mis_cnt_q <= '0;
         // NOTE: the tiny queue storage is reset so the head-driven commit outputs read zero.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_done) begin
         // Everything still queued is younger than the mispredict: wrong path.
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= entry_in;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            bjp_cnt_q <= bjp_cnt_q + 32'(head.bjp);
            mis_cnt_q <= mis_cnt_q + 32'(head.mis);
            if (head.mis) flush_pc <= head.tgt;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_exu_bjp_cmtgen.sv
// Scoreboard bench for exu_bjp_cmtgen: directed corner cases followed by random handshake stress.
module tb_exu_bjp_cmtgen;
   localparam int DEPTH         = 2;
   localparam int N_STRESS      = 10000;
   localparam int STRESS_BUDGET = 60000;

   typedef struct {
      bit        bjp;
      bit        prdt;
      bit        mis;
      bit [31:0] pc;
      bit [31:0] imm;
      bit [31:0] tgt;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   // reference model state
   ent_t      sb_q[$];
   bit        m_known = 1'b0;
   bit        m_flush = 1'b0;
   bit [31:0] m_flush_pc = '0;
   bit [31:0] m_bjp_cnt  = '0;
   bit [31:0] m_mis_cnt  = '0;
   int        m_pushes   = 0;
   bit        exp_ready, exp_valid, do_pop, do_push;
   ent_t      m_ent;

   exu_bjp_cmtgen_if #(.PC_SIZE(32), .XLEN(32)) bus ();

   exu_bjp_cmtgen #(.DEPTH(DEPTH), .PC_SIZE(32), .XLEN(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit b, input bit p, input bit t,
                        input logic [31:0] pc, input logic [31:0] imm);
      bus.bjp_i_valid = v;
      bus.bjp_i_bjp   = b;
      bus.bjp_i_prdt  = p;
      bus.bjp_i_taken = t;
      bus.bjp_i_pc    = pc;
      bus.bjp_i_imm   = imm;
   endtask

   // Monitor + model: compare at the falling edge, then advance the model with the inputs
   // that the next rising edge will sample (inputs only change just after rising edges).
   initial forever begin
      @(negedge clk);
      exp_ready = !m_flush && (sb_q.size() < DEPTH);
      exp_valid = !m_flush && (sb_q.size() > 0);
      if (m_known) begin
         check("bjp_i_ready", bus.bjp_i_ready, exp_ready);
         check("cmt_o_valid", bus.cmt_o_valid, exp_valid);
         check("flush_o_req", bus.flush_o_req, m_flush);
         check("flush_o_pc",  bus.flush_o_pc,  m_flush_pc);
         check("bjp_cnt",     bus.bjp_cnt,     m_bjp_cnt);
         check("mis_cnt",     bus.mis_cnt,     m_mis_cnt);
         if (exp_valid) begin
            check("cmt_o_pc",       bus.cmt_o_pc,       sb_q[0].pc);
            check("cmt_o_imm",      bus.cmt_o_imm,      sb_q[0].imm);
            check("cmt_o_bjp",      bus.cmt_o_bjp,      sb_q[0].bjp);
            check("cmt_o_bjp_prdt", bus.cmt_o_bjp_prdt, sb_q[0].prdt);
         end
      end
      if (rst) begin
         sb_q.delete();
         m_flush    = 1'b0;
         m_flush_pc = '0;
         m_bjp_cnt  = '0;
         m_mis_cnt  = '0;
         m_known    = 1'b1;
      end else if (m_known) begin
         if (m_flush) begin
            if (bus.flush_o_ack) begin
               sb_q.delete();
               m_flush = 1'b0;
            end
         end else begin
            do_pop  = exp_valid && bus.cmt_o_ready;
            do_push = bus.bjp_i_valid && exp_ready;
            if (do_pop) begin
               m_ent = sb_q.pop_front();
               if (m_ent.bjp) m_bjp_cnt++;
               if (m_ent.mis) begin
                  m_mis_cnt++;
                  m_flush    = 1'b1;
                  m_flush_pc = m_ent.tgt;
               end
            end
            if (do_push) begin
               m_ent.bjp  = bus.bjp_i_bjp;
               m_ent.prdt = bus.bjp_i_prdt;
               m_ent.mis  = bus.bjp_i_bjp && (bus.bjp_i_prdt != bus.bjp_i_taken);
               m_ent.pc   = bus.bjp_i_pc;
               m_ent.imm  = bus.bjp_i_imm;
               m_ent.tgt  = bus.bjp_i_taken ? bus.bjp_i_pc + bus.bjp_i_imm : bus.bjp_i_pc + 32'd4;
               sb_q.push_back(m_ent);
               m_pushes++;
            end
         end
      end
   end

   // Push one mispredicting branch, commit it, check the redirect, then acknowledge it.
   task automatic mispredict_flush(input string name, input bit p, input bit t,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] exp_pc);
      bus.cmt_o_ready = 1'b1;
      drive(1'b1, 1'b1, p, t, pc, imm);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      @(negedge clk);
      check({name, "_req"}, bus.flush_o_req, 1'b1);
      check({name, "_pc"},  bus.flush_o_pc,  exp_pc);
      step();
      bus.flush_o_ack = 1'b1;
      step();
      bus.flush_o_ack = 1'b0;
   endtask

   int cyc;
   int start_pushes;
   int drain;
   bit p_bit;

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.cmt_o_ready = 1'b0;
      bus.flush_o_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready",     bus.bjp_i_ready, 1'b1);
      check("rst_valid",     bus.cmt_o_valid, 1'b0);
      check("rst_flush_req", bus.flush_o_req, 1'b0);
      check("rst_flush_pc",  bus.flush_o_pc,  32'h0);
      check("rst_cmt_pc",    bus.cmt_o_pc,    32'h0);
      check("rst_mis_cnt",   bus.mis_cnt,     32'h0);

      // first entry becomes visible the cycle after its push
      step();
      bus.cmt_o_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("first_valid",   bus.cmt_o_valid, 1'b1);
      check("first_pc",      bus.cmt_o_pc,    32'h8000_0000);
      check("first_bjp_cnt", bus.bjp_cnt,     32'h0);
      step();

      // fill to DEPTH, then push+pop while full: only the pop happens
      bus.cmt_o_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h4);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h4);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h4);
      bus.cmt_o_ready = 1'b1;
      @(negedge clk);
      check("full_ready", bus.bjp_i_ready, 1'b0);
      check("full_head",  bus.cmt_o_pc,    32'h100);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("full_pop_ready", bus.bjp_i_ready, 1'b1);
      check("full_pop_head",  bus.cmt_o_pc,    32'h104);
      step();

      // mispredicted taken branch with a younger entry behind it, ack 3 cycles later
      bus.cmt_o_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 32'h20);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.cmt_o_ready = 1'b1;
      step();
      @(negedge clk);
      check("mis_req",      bus.flush_o_req, 1'b1);
      check("mis_pc",       bus.flush_o_pc,  32'h8000_0030);
      check("mis_valid",    bus.cmt_o_valid, 1'b0);
      check("mis_ready",    bus.bjp_i_ready, 1'b0);
      check("mis_cnt_one",  bus.mis_cnt,     32'h1);
      check("mis_bjp_cnt",  bus.bjp_cnt,     32'h1);
      step();
      step();
      bus.flush_o_ack = 1'b1;
      @(negedge clk);
      check("hold_req", bus.flush_o_req, 1'b1);
      check("hold_pc",  bus.flush_o_pc,  32'h8000_0030);
      step();
      bus.flush_o_ack = 1'b0;
      @(negedge clk);
      check("ack_req",     bus.flush_o_req, 1'b0);
      check("ack_discard", bus.cmt_o_valid, 1'b0);
      check("ack_ready",   bus.bjp_i_ready, 1'b1);
      step();

      // redirect target arithmetic, including modulo-2^32 wrap
      mispredict_flush("tgt_taken", 1'b0, 1'b1, 32'h0000_0200, 32'h10, 32'h0000_0210);
      mispredict_flush("wrap_nt",   1'b1, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'h0000_0000);
      mispredict_flush("tgt_mid",   1'b1, 1'b0, 32'h0000_0500, 32'h40, 32'h0000_0504);
      mispredict_flush("wrap_tk",   1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000);

      // reset while a flush is pending and unacknowledged
      bus.cmt_o_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h8);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.cmt_o_ready = 1'b1;
      step();
      @(negedge clk);
      check("pre_rst_req", bus.flush_o_req, 1'b1);
      step();
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("frst_req",     bus.flush_o_req, 1'b0);
      check("frst_valid",   bus.cmt_o_valid, 1'b0);
      check("frst_ready",   bus.bjp_i_ready, 1'b1);
      check("frst_bjp_cnt", bus.bjp_cnt,     32'h0);
      check("frst_mis_cnt", bus.mis_cnt,     32'h0);
      check("frst_pc",      bus.flush_o_pc,  32'h0);

      // random stress
      start_pushes = m_pushes;
      cyc = 0;
      while ((m_pushes - start_pushes) < N_STRESS && cyc < STRESS_BUDGET) begin
         step();
         p_bit = 1'($urandom_range(0, 1));
         drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), p_bit,
               ($urandom_range(0, 3) == 0) ? !p_bit : p_bit, $urandom, $urandom);
         bus.cmt_o_ready = $urandom_range(0, 9) < 7;
         bus.flush_o_ack = $urandom_range(0, 3) == 0;
         rst = ($urandom_range(0, 2999) == 0);
         cyc++;
      end
      check("stress_budget", (m_pushes - start_pushes) >= N_STRESS, 1'b1);

      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.cmt_o_ready = 1'b1;
      bus.flush_o_ack = 1'b1;
      drain = 0;
      while ((sb_q.size() != 0 || m_flush) && drain < 20) begin
         step();
         drain++;
      end
      check("drain_done", (sb_q.size() == 0) && !m_flush, 1'b1);
      @(negedge clk);
      check("final_bjp_cnt", bus.bjp_cnt, m_bjp_cnt);
      check("final_mis_cnt", bus.mis_cnt, m_mis_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
